// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter feeding several byte streams into one UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 16,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_transmit,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_is_transmitting,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic                 err
);
  typedef enum logic [2:0] {IDLE, SEND, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [GW-1:0] ptr, sel, idx;
  logic [7:0] burst;
  logic [1:0] tmo;
  logic last_q, acc, done, timeout, rel;
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      idx = GW'((int'(ptr) + j) % NUM_REQ);
      if (req_valid[idx]) sel = idx;
    end
  end
  always_comb begin
    req_ready = '0;
    if (state == SEND && !uart_is_transmitting) req_ready[grant_id] = 1'b1;
  end
  assign acc = state == SEND && !uart_is_transmitting && req_valid[grant_id];
  assign done = last_q || burst == 8'(MAX_BURST);
  assign timeout = state == WAIT_BUSY && !uart_is_transmitting && tmo == 2'd3;
  assign rel = timeout || (state == WAIT_DONE && !uart_is_transmitting && done);
  assign uart_transmit = state == START;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = |req_valid && !uart_is_transmitting ? SEND : IDLE;
      SEND:      state_n = acc ? START : SEND;
      START:     state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = uart_is_transmitting ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      WAIT_DONE: state_n = uart_is_transmitting ? WAIT_DONE : done ? IDLE : SEND;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant_valid <= 1'b0;
      grant_id <= '0;
      uart_tx_byte <= 8'h00;
      err <= 1'b0;
      burst <= 8'd0;
      last_q <= 1'b0;
      tmo <= 2'd0;
    end else begin
      state <= state_n;
      err <= timeout;
      tmo <= state == WAIT_BUSY ? tmo + 2'd1 : 2'd0;
      if (state == IDLE && state_n == SEND) begin
        grant_id <= sel;
        grant_valid <= 1'b1;
        burst <= 8'd0;
      end
      if (acc) begin
        uart_tx_byte <= req_data[{grant_id, 3'b000} +: 8];
        last_q <= req_last[grant_id];
        burst <= burst == 8'(MAX_BURST) ? burst : burst + 8'd1;
      end
      if (rel) begin
        ptr <= grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        grant_valid <= 1'b0;
        grant_id <= '0;
      end
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (legal 2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, max bytes per grant before forced release (legal 1..255).
REQ-003 SHALL define GW = clog2(NUM_REQ) as the grant index width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_last  input  NUM_REQ  marks the final byte of a packet; sampled with the byte.
REQ-009 SHALL have port req_ready  output  NUM_REQ  byte accepted when valid&ready.
REQ-010 SHALL have port uart_transmit  output  1  start pulse to the UART transmitter.
REQ-011 SHALL have port uart_tx_byte  output  8  byte presented to the UART.
REQ-012 SHALL have port uart_is_transmitting  input  1  UART transmitter busy.
REQ-013 SHALL have port grant_valid  output  1  a requester currently holds the lock.
REQ-014 SHALL have port grant_id  output  GW  index of the lock holder; 0 when grant_valid=0.
REQ-015 SHALL have port err  output  1  one-cycle pulse on UART start timeout.

Function
REQ-016 SHALL implement the states IDLE, SEND, START, WAIT_BUSY and WAIT_DONE.
REQ-017 IDLE: if any req_valid=1 and uart_is_transmitting=0, SHALL select the first valid requester in round-robin order starting at ptr, register it as grant_id, set grant_valid=1, clear the burst count and go to SEND.
REQ-018 SEND: req_ready[grant_id] SHALL be asserted combinationally only in this state and only while uart_is_transmitting=0; all other ready bits SHALL be 0.
REQ-019 SEND: on valid&ready, SHALL register the byte into uart_tx_byte, register req_last into last_q, increment the burst count and go to START.
REQ-020 SEND: while the lock holder's valid=0, SHALL remain in SEND and hold the lock; a stalled packet is not preempted.
REQ-021 START: uart_transmit SHALL be 1 for exactly this one cycle, then the FSM SHALL go to WAIT_BUSY.
REQ-022 WAIT_BUSY: on uart_is_transmitting=1 SHALL go to WAIT_DONE; if it is not seen within 4 cycles of leaving START, SHALL pulse err for 1 cycle, release the lock and go to IDLE.
REQ-023 WAIT_DONE: on uart_is_transmitting=0, SHALL release the lock and go to IDLE if last_q=1 or the burst count equals MAX_BURST; otherwise SHALL go to SEND with the same grant.
REQ-024 Release SHALL set ptr=(grant_id+1) mod NUM_REQ, grant_valid=0 and grant_id=0.
REQ-025 Requests arriving in any state other than IDLE SHALL be deferred; they SHALL NOT be dropped and SHALL NOT preempt the lock holder.
REQ-026 uart_tx_byte SHALL hold its value from START until the next accepted byte.
REQ-027 The burst counter SHALL be 8 bits and SHALL saturate at MAX_BURST, never wrapping.
REQ-028 Minimum per-byte overhead is 3 cycles plus UART busy time: SEND accept -> START -> WAIT_BUSY -> WAIT_DONE.

Reset
REQ-029 On rst=1 SHALL set: state=IDLE, ptr=0, grant_valid=0, grant_id=0, uart_transmit=0, uart_tx_byte=8'h00, err=0, req_ready=0, burst count=0, last_q=0.
REQ-030 rst asserted mid-packet SHALL abort the lock immediately with no further transmit pulse; the UART is reset by the same rst.
REQ-031 rst SHALL take priority over every transition.

Verification
REQ-032 Single requester: req0 sends bytes 0x41,0x42 (last on 0x42) -> exactly 2 uart_transmit pulses carrying 0x41 then 0x42; grant released; ptr=1.
REQ-033 Contention: req0 and req2 valid at the same time, ptr=0, each with a 1-byte packet -> req0 is served first, then req2; after release ptr=3.
REQ-034 Packet lock: req1 sends a 3-byte packet while req0 is valid -> all 3 req1 bytes are sent contiguously before any req0 byte.
REQ-035 Burst limit: MAX_BURST=2, req3 streams 5 bytes with last never asserted and req0 valid -> req3 sends 2 bytes, req0 is served, then req3 resumes.
REQ-036 Timeout: uart_is_transmitting tied to 0 -> err pulses 1 cycle, 5 cycles after START; FSM returns to IDLE.
REQ-037 Reset mid-packet: rst in WAIT_DONE -> the next cycle shows all outputs at their reset values and no transmit pulse.
